// File: rtl/cnt_pkg.sv
// Shared definitions for the two-digit BCD key counter: FSM encoding,
// BCD limits and the default 50 MHz timing constants.
package cnt_pkg;

    // FSM state encoding, 3 bits wide
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HOLD_INC = 3'd1;
    localparam logic [2:0] ST_RPT_INC  = 3'd2;
    localparam logic [2:0] ST_HOLD_DEC = 3'd3;
    localparam logic [2:0] ST_RPT_DEC  = 3'd4;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX = 4'h9;

    // Default timing at 50 MHz: 500 ms before auto-repeat, then 100 ms per step
    localparam int unsigned HOLD_CYC_DEF = 25_000_000;
    localparam int unsigned RPT_CYC_DEF  = 5_000_000;
    localparam int unsigned TMR_W_DEF    = 25;

    // Clamp a nibble into the BCD range so a corrupted digit behaves as 9
    function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD up/down register with wrap flag. The step inputs are
// single-cycle commands; clr has priority and never raises wrap.
module bcd2_updown
    import cnt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       step_inc,
    input  logic       step_dec,
    output logic [7:0] cnt,
    output logic       wrap
);

    logic [3:0] tens_sat;
    logic [3:0] units_sat;
    logic [7:0] cnt_nxt;
    logic       wrap_nxt;

    // Next count and wrap flag from the current digits and the step command
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        tens_sat  = bcd_sat(cnt[7:4]);
        units_sat = bcd_sat(cnt[3:0]);
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;
        if (clr) begin
            cnt_nxt = 8'h00;
        end else if (step_inc) begin
            if (units_sat != BCD_MAX) begin
                cnt_nxt = {tens_sat, units_sat + 4'd1};
            end else if (tens_sat != BCD_MAX) begin
                cnt_nxt = {tens_sat + 4'd1, 4'd0};
            end else begin
                cnt_nxt  = 8'h00;
                wrap_nxt = 1'b1;
            end
        end else if (step_dec) begin
            if (units_sat != 4'd0) begin
                cnt_nxt = {tens_sat, units_sat - 4'd1};
            end else if (tens_sat != 4'd0) begin
                cnt_nxt = {tens_sat - 4'd1, BCD_MAX};
            end else begin
                cnt_nxt  = {BCD_MAX, BCD_MAX};
                wrap_nxt = 1'b1;
            end
        end
    end

    // Count and wrap registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            cnt  <= 8'h00;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: rtl/cnt_key_ctrl.sv
// Key controller for the two-digit BCD display counter. Arbitrates clear,
// increment and decrement keys, adds long-press auto-repeat and drives the
// BCD register with single-cycle step commands.
module cnt_key_ctrl
    import cnt_pkg::*;
#(
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
    parameter int unsigned RPT_CYC  = RPT_CYC_DEF,
    parameter int unsigned TMR_W    = TMR_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_inc_rise,
    input  logic       key_inc_lvl,
    input  logic       key_dec_rise,
    input  logic       key_dec_lvl,
    input  logic       key_clr_rise,
    output logic [7:0] cnt_out,
    output logic       cnt_step,
    output logic       cnt_wrap,
    output logic       busy
);

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             do_inc;
    logic             do_dec;
    logic             do_clr;

    // Arbitration and press/hold/repeat sequencing; clear wins over everything
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        do_inc    = 1'b0;
        do_dec    = 1'b0;
        do_clr    = 1'b0;
        if (key_clr_rise) begin
            do_clr    = 1'b1;
            state_nxt = ST_IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmr_nxt = '0;
                    if (key_inc_rise) begin
                        do_inc    = 1'b1;
                        state_nxt = ST_HOLD_INC;
                    end else if (key_dec_rise) begin
                        do_dec    = 1'b1;
                        state_nxt = ST_HOLD_DEC;
                    end
                end
                ST_HOLD_INC: begin
                    if (!key_inc_lvl) begin
                        state_nxt = ST_IDLE;
                        tmr_nxt   = '0;
                    end else if (tmr == HOLD_LAST) begin
                        do_inc    = 1'b1;
                        state_nxt = ST_RPT_INC;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_ONE;
                    end
                end
                ST_RPT_INC: begin
                    if (!key_inc_lvl) begin
                        state_nxt = ST_IDLE;
                        tmr_nxt   = '0;
                    end else if (tmr == RPT_LAST) begin
                        do_inc  = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_ONE;
                    end
                end
                ST_HOLD_DEC: begin
                    if (!key_dec_lvl) begin
                        state_nxt = ST_IDLE;
                        tmr_nxt   = '0;
                    end else if (tmr == HOLD_LAST) begin
                        do_dec    = 1'b1;
                        state_nxt = ST_RPT_DEC;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_ONE;
                    end
                end
                ST_RPT_DEC: begin
                    if (!key_dec_lvl) begin
                        state_nxt = ST_IDLE;
                        tmr_nxt   = '0;
                    end else if (tmr == RPT_LAST) begin
                        do_dec  = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    // FSM state, timer, step pulse and busy flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            cnt_step <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            cnt_step <= do_inc | do_dec;
            // Registered from the next state so busy tracks the state register
            busy     <= (state_nxt != ST_IDLE);
        end
    end

    bcd2_updown u_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (do_clr),
        .step_inc (do_inc),
        .step_dec (do_dec),
        .cnt      (cnt_out),
        .wrap     (cnt_wrap)
    );

endmodule

// File: tb/tb_cnt_key_ctrl.sv
// Scoreboard bench for cnt_key_ctrl with short hold/repeat timing.
module tb_cnt_key_ctrl;

    localparam int unsigned HOLD = 10;
    localparam int unsigned RPT  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_inc_rise = 1'b0;
    logic       key_inc_lvl = 1'b0;
    logic       key_dec_rise = 1'b0;
    logic       key_dec_lvl = 1'b0;
    logic       key_clr_rise = 1'b0;
    logic [7:0] cnt_out;
    logic       cnt_step;
    logic       cnt_wrap;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       wrap;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    cnt_key_ctrl #(
        .HOLD_CYC (HOLD),
        .RPT_CYC  (RPT),
        .TMR_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_inc_rise (key_inc_rise),
        .key_inc_lvl  (key_inc_lvl),
        .key_dec_rise (key_dec_rise),
        .key_dec_lvl  (key_dec_lvl),
        .key_clr_rise (key_clr_rise),
        .cnt_out      (cnt_out),
        .cnt_step     (cnt_step),
        .cnt_wrap     (cnt_wrap),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic expect_step(input int at_cyc, input logic [7:0] c, input logic w);
        exp_t e;
        e.cyc  = at_cyc;
        e.cnt  = c;
        e.wrap = w;
        sb_q.push_back(e);
    endtask

    // Monitor: every step pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (cnt_wrap) check("wrap_has_step", 32'(cnt_step), 32'd1);
            if (cnt_step) begin
                check("step_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("step_cycle", 32'(cyc), 32'(e.cyc));
                    check("step_cnt", 32'(cnt_out), 32'(e.cnt));
                    check("step_wrap", 32'(cnt_wrap), 32'(e.wrap));
                end
            end
        end
    end

    // Short press: level held for three cycles, pulses must be one cycle wide
    task automatic tap(input logic is_inc, input logic [7:0] exp_cnt, input logic exp_wrap);
        @(negedge clk);
        expect_step(cyc + 1, exp_cnt, exp_wrap);
        if (is_inc) begin
            key_inc_rise = 1'b1;
            key_inc_lvl  = 1'b1;
        end else begin
            key_dec_rise = 1'b1;
            key_dec_lvl  = 1'b1;
        end
        @(negedge clk);
        key_inc_rise = 1'b0;
        key_dec_rise = 1'b0;
        @(negedge clk);
        check("tap_step_width", 32'(cnt_step), 32'd0);
        check("tap_wrap_width", 32'(cnt_wrap), 32'd0);
        @(negedge clk);
        key_inc_lvl = 1'b0;
        key_dec_lvl = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cnt_held", 32'(cnt_out), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cnt", 32'(cnt_out), 32'h00);
        check("rst_step", 32'(cnt_step), 32'd0);
        check("rst_wrap", 32'(cnt_wrap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Tap and wrap: 00 -> 99 -> 98 -> 99 -> 00 -> 99 -> 00
        tap(1'b0, 8'h99, 1'b1);
        tap(1'b0, 8'h98, 1'b0);
        tap(1'b1, 8'h99, 1'b0);
        tap(1'b1, 8'h00, 1'b1);
        tap(1'b0, 8'h99, 1'b1);
        tap(1'b1, 8'h00, 1'b1);
        for (int v = 1; v <= 5; v++) tap(1'b1, to_bcd(v), 1'b0);
        check("pre_long_cnt", 32'(cnt_out), 32'h05);

        // Long press from 05
        @(negedge clk);
        c0 = cyc;
        expect_step(c0 + 1,  8'h06, 1'b0);
        expect_step(c0 + 11, 8'h07, 1'b0);
        expect_step(c0 + 15, 8'h08, 1'b0);
        expect_step(c0 + 19, 8'h09, 1'b0);
        expect_step(c0 + 23, 8'h10, 1'b0);
        expect_step(c0 + 27, 8'h11, 1'b0);
        expect_step(c0 + 31, 8'h12, 1'b0);
        key_inc_rise = 1'b1;
        key_inc_lvl  = 1'b1;
        @(negedge clk);
        key_inc_rise = 1'b0;
        wait_until(c0 + 20);
        check("long_busy", 32'(busy), 32'd1);
        wait_until(c0 + 31);
        key_inc_lvl = 1'b0;
        @(negedge clk);
        check("long_release_busy", 32'(busy), 32'd0);
        wait_until(c0 + 45);
        check("long_final_cnt", 32'(cnt_out), 32'h12);

        // Walk to 50
        for (int v = 13; v <= 50; v++) tap(1'b1, to_bcd(v), 1'b0);

        // Simultaneous inc+dec: increment wins and repeats as increment
        @(negedge clk);
        c0 = cyc;
        expect_step(c0 + 1,  8'h51, 1'b0);
        expect_step(c0 + 11, 8'h52, 1'b0);
        expect_step(c0 + 15, 8'h53, 1'b0);
        key_inc_rise = 1'b1;
        key_inc_lvl  = 1'b1;
        key_dec_rise = 1'b1;
        key_dec_lvl  = 1'b1;
        @(negedge clk);
        key_inc_rise = 1'b0;
        key_dec_rise = 1'b0;
        check("simul_busy", 32'(busy), 32'd1);
        wait_until(c0 + 12);
        key_dec_rise = 1'b1;   // during RPT_INC: must be ignored
        @(negedge clk);
        key_dec_rise = 1'b0;
        wait_until(c0 + 16);
        key_inc_lvl = 1'b0;
        key_dec_lvl = 1'b0;
        wait_until(c0 + 25);
        check("simul_final_cnt", 32'(cnt_out), 32'h53);
        check("simul_idle", 32'(busy), 32'd0);

        // Walk down to 45, then long decrement to reach RPT_DEC at 42
        for (int v = 52; v >= 45; v--) tap(1'b0, to_bcd(v), 1'b0);
        @(negedge clk);
        c0 = cyc;
        expect_step(c0 + 1,  8'h44, 1'b0);
        expect_step(c0 + 11, 8'h43, 1'b0);
        expect_step(c0 + 15, 8'h42, 1'b0);
        key_dec_rise = 1'b1;
        key_dec_lvl  = 1'b1;
        @(negedge clk);
        key_dec_rise = 1'b0;
        wait_until(c0 + 16);
        key_clr_rise = 1'b1;
        key_inc_rise = 1'b1;
        @(negedge clk);
        key_clr_rise = 1'b0;
        key_inc_rise = 1'b0;
        check("clr_cnt", 32'(cnt_out), 32'h00);
        check("clr_step", 32'(cnt_step), 32'd0);
        check("clr_wrap", 32'(cnt_wrap), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        wait_until(c0 + 40);
        check("clr_hold_cnt", 32'(cnt_out), 32'h00);
        key_dec_lvl = 1'b0;
        @(negedge clk);

        // Units borrow 20 -> 19
        for (int v = 1; v <= 20; v++) tap(1'b1, to_bcd(v), 1'b0);
        tap(1'b0, 8'h19, 1'b0);

        // Asynchronous reset mid-count while a press is held
        for (int v = 20; v <= 36; v++) tap(1'b1, to_bcd(v), 1'b0);
        @(negedge clk);
        c0 = cyc;
        expect_step(c0 + 1, 8'h37, 1'b0);
        key_inc_rise = 1'b1;
        key_inc_lvl  = 1'b1;
        @(negedge clk);
        key_inc_rise = 1'b0;
        check("prerst_cnt", 32'(cnt_out), 32'h37);
        @(negedge clk);
        check("prerst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt_out), 32'h00);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_step", 32'(cnt_step), 32'd0);
        rst_n = 1'b1;
        wait_until(c0 + 25);
        key_inc_lvl = 1'b0;
        @(negedge clk);
        check("post_rst_cnt", 32'(cnt_out), 32'h00);
        check("post_rst_busy", 32'(busy), 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
